// File: rtl/mem_access_ctrl.sv
// Byte/halfword/word access controller between a CPU load/store port and a
// word-wide memory; sub-word stores become read-modify-write sequences.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_load,
  input  logic [1:0]  cpu_store,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SB  = 2'b01;
  localparam logic [1:0] ST_SH  = 2'b10;

  // Abort fires on the cycle the count would reach TIMEOUT.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        err_q, err_d;

  logic        access_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Illegal codes and misalignment are rejected before touching memory.
  always_comb begin
    access_err = 1'b0;
    if (cpu_we) begin
      case (cpu_store)
        ST_SW:   access_err = (cpu_addr[1:0] != 2'b00);
        ST_SB:   access_err = 1'b0;
        ST_SH:   access_err = cpu_addr[0];
        default: access_err = 1'b1;
      endcase
    end else begin
      case (cpu_load)
        LD_LW:          access_err = (cpu_addr[1:0] != 2'b00);
        LD_LB, LD_LBU:  access_err = 1'b0;
        LD_LH, LD_LHU:  access_err = cpu_addr[0];
        default:        access_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    lane_byte = mem_rdata[{cpu_addr[1:0], 3'b000} +: 8];
    lane_half = cpu_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (cpu_load)
      LD_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
      LD_LBU:  load_ext = {24'h0, lane_byte};
      LD_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
      LD_LHU:  load_ext = {16'h0, lane_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (cpu_store == ST_SB) begin
      merged[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata[7:0];
    end else begin
      merged[{cpu_addr[1], 4'b0000} +: 16] = cpu_wdata[15:0];
    end
  end

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    wbuf_d  = wbuf_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          err_d  = access_err;
          wdog_d = 8'd0;
          if (access_err)                          state_d = DONE;
          else if (cpu_we && cpu_store == ST_SW)   state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD: begin
        if (mem_ack) begin
          wdog_d = 8'd0;
          if (cpu_we) begin
            wbuf_d  = merged;
            state_d = WR;
          end else begin
            rdata_d = load_ext;
            state_d = DONE;
          end
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      WR: begin
        if (mem_ack) begin
          state_d = DONE;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      wbuf_q  <= 32'h0;
      wdog_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      wbuf_q  <= wbuf_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q == RD) || (state_q == WR);
  assign mem_we    = (state_q == WR);
  assign mem_addr  = {cpu_addr[31:2], 2'b00};
  assign mem_wdata = (cpu_store == ST_SW) ? cpu_wdata : wbuf_q;
  assign cpu_done  = (state_q == DONE);
  assign cpu_err   = cpu_done && err_q;
  assign cpu_stall = cpu_req && !cpu_done;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bench for mem_access_ctrl with a word memory model
// and an arithmetic reference for extension, merging, errors and latency.
module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_load;
  logic [1:0]  cpu_store;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_done, cpu_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_load(cpu_load), .cpu_store(cpu_store),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned b = (w >> (8 * addr[1:0])) & 32'hFF;
    int unsigned h = (w >> (16 * addr[1])) & 32'hFFFF;
    case (ld)
      3'd0:    return w;
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h - 65536 : h;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [1:0] st, input logic [31:0] addr,
                                            input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m = ((st == 2'd1) ? 32'hFF : 32'hFFFF) << (8 * addr[1:0]);
    return (old & ~m) | ((wd << (8 * addr[1:0])) & m);
  endfunction

  // One access: drive in an IDLE cycle, serve memory with ack delay d per
  // phase, then compare outcome against the reference.
  task automatic access(input logic we, input logic [2:0] ld, input logic [1:0] st,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int d, input bit keep);
    int sz, cyc, cnt, reads, writes, req_cycles;
    int exp_cyc, exp_reads, exp_writes, exp_req;
    bit illegal, exp_err, done_seen;
    logic [7:0]  idx = addr[9:2];
    logic [31:0] old_word, exp_word;

    @(negedge clk);
    check("idle_before_req", {30'b0, mem_req, cpu_done}, 32'h0);
    cpu_req = 1'b1; cpu_we = we; cpu_load = ld; cpu_store = st;
    cpu_addr = addr; cpu_wdata = wd;

    old_word = mem[idx];
    if (we) begin
      illegal = (st == 2'd3);
      sz = (st == 2'd0) ? 4 : (st == 2'd1) ? 1 : 2;
    end else begin
      illegal = (ld > 3'd4);
      sz = (ld == 3'd0) ? 4 : (ld == 3'd1 || ld == 3'd2) ? 1 : 2;
    end
    exp_err = illegal || (addr % sz != 0);
    exp_word = old_word; exp_reads = 0; exp_writes = 0; exp_req = 0;
    if (exp_err) begin
      exp_cyc = 1;
    end else if (d >= T) begin
      exp_cyc = 1 + T; exp_err = 1'b1; exp_req = T;
    end else if (we && st != 2'd0) begin
      exp_cyc = 3 + 2 * d; exp_reads = 1; exp_writes = 1; exp_req = 2 * (d + 1);
      exp_word = ref_merge(st, addr, old_word, wd);
    end else begin
      exp_cyc = 2 + d; exp_req = d + 1;
      if (we) begin exp_writes = 1; exp_word = wd; end
      else begin exp_reads = 1; exp_rdata = ref_load(ld, addr, old_word); end
    end

    cyc = 0; cnt = 0; reads = 0; writes = 0; req_cycles = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (cpu_done) begin
        done_seen = 1'b1;
      end else begin
        check("err_without_done", {31'b0, cpu_err}, 32'h0);
        if (mem_req) begin
          req_cycles++;
          if (cnt == d) begin
            mem_ack = 1'b1;
            cnt = 0;
            check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            if (mem_we) begin
              mem[idx] = mem_wdata;
              writes++;
            end else begin
              mem_rdata = mem[idx];
              reads++;
            end
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end

    check("done_seen", {31'b0, done_seen}, 32'h1);
    check("latency", cyc, exp_cyc);
    check("cpu_err", {31'b0, cpu_err}, {31'b0, exp_err});
    check("cpu_stall_at_done", {31'b0, cpu_stall}, 32'h0);
    check("cpu_rdata", cpu_rdata, exp_rdata);
    check("reads", reads, exp_reads);
    check("writes", writes, exp_writes);
    check("mem_req_cycles", req_cycles, exp_req);
    check("mem_word", mem[idx], exp_word);
    if (!keep) cpu_req = 1'b0;
  endtask

  initial begin
    bit keep_r;
    int d_r;
    rstn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_load = 3'd0; cpu_store = 2'd0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    exp_rdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_cpu_done", {31'b0, cpu_done}, 32'h0);
    check("rst_cpu_err", {31'b0, cpu_err}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    rstn = 1'b1;

    // lb from 0x103 of 0x80FF_1234 sign-extends 0x80.
    mem[8'h40] = 32'h80FF_1234;
    access(1'b0, 3'd1, 2'd0, 32'h103, 32'h0, 0, 1'b0);
    check("lb_fixed_value", cpu_rdata, 32'hFFFF_FF80);

    // sh to 0x202 over 0x1122_3344.
    mem[8'h80] = 32'h1122_3344;
    access(1'b1, 3'd0, 2'd2, 32'h202, 32'h0000_ABCD, 0, 1'b0);
    check("sh_fixed_word", mem[8'h80], 32'hABCD_3344);

    // Misaligned lw: error, no memory traffic.
    access(1'b0, 3'd0, 2'd0, 32'h301, 32'h0, 0, 1'b0);

    // sw with no ack ever: watchdog abort after T cycles.
    access(1'b1, 3'd0, 2'd0, 32'h010, 32'hDEAD_BEEF, 100, 1'b0);

    // Illegal codes.
    access(1'b0, 3'd6, 2'd0, 32'h020, 32'h0, 0, 1'b0);
    access(1'b1, 3'd0, 2'd3, 32'h024, 32'h1234_5678, 0, 1'b0);

    // Back-to-back lw then sb with cpu_req held through DONE.
    access(1'b0, 3'd0, 2'd0, 32'h044, 32'h0, 1, 1'b1);
    access(1'b1, 3'd0, 2'd1, 32'h049, 32'h0000_005A, 2, 1'b0);

    // lhu waiting on a slow ack, reset pulsed mid-wait.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_load = 3'd4; cpu_addr = 32'h0A2;
    repeat (2) @(negedge clk);
    check("midrst_req_before", {31'b0, mem_req}, 32'h1);
    rstn = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    exp_rdata = 32'h0;
    check("midrst_mem_req", {31'b0, mem_req}, 32'h0);
    check("midrst_cpu_done", {31'b0, cpu_done}, 32'h0);
    check("midrst_cpu_rdata", cpu_rdata, exp_rdata);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_no_done", {30'b0, cpu_done, mem_req}, 32'h0);
    end

    // Randomized accesses including sub-word RMW, errors and timeouts.
    for (int n = 0; n < 60; n++) begin
      d_r = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
      keep_r = $urandom_range(0, 1);
      access($urandom_range(0, 1), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1023), $urandom, d_r, keep_r);
    end
    cpu_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of cycles to wait for mem_ack before aborting (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rstn  input  1  synchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU requests a data-memory access; held with its qualifiers until cpu_done.
REQ-005 cpu_we  input  1  1 = store, 0 = load.
REQ-006 cpu_load  input  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu.
REQ-007 cpu_store  input  2  store type: 00 sw, 01 sb, 10 sh.
REQ-008 cpu_addr  input  32  byte address.
REQ-009 cpu_wdata  input  32  store data, right-aligned for sb/sh.
REQ-010 cpu_rdata  output  32  extended load result, registered.
REQ-011 cpu_stall  output  1  CPU hold: cpu_req & ~cpu_done.
REQ-012 cpu_done  output  1  one-cycle completion pulse.
REQ-013 cpu_err  output  1  valid with cpu_done: misaligned, illegal code or timeout.
REQ-014 mem_req  output  1  word-memory request.
REQ-015 mem_we  output  1  1 = word write.
REQ-016 mem_addr  output  32  {cpu_addr[31:2], 2'b00}.
REQ-017 mem_wdata  output  32  full word to write.
REQ-018 mem_rdata  input  32  read word, valid with mem_ack.
REQ-019 mem_ack  input  1  completes the current mem_req; may assert in the same cycle mem_req rises.

Function
REQ-020 FSM states IDLE, RD, WR, DONE; mem_req = (RD|WR), mem_we = WR, cpu_done = DONE, all decoded from the state register.
REQ-021 IDLE with cpu_req=1: error check first; error -> DONE with err flag set, no memory access; else load or sb/sh -> RD, sw -> WR.
REQ-022 Error conditions: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0; cpu_load 101-111 on load; cpu_store 11 on store.
REQ-023 RD with mem_ack: load -> DONE, capturing the extended result into cpu_rdata; sb/sh -> WR, capturing the merged word into the write buffer.
REQ-024 WR with mem_ack -> DONE; mem_wdata = cpu_wdata for sw, merge buffer for sb/sh.
REQ-025 DONE -> IDLE unconditionally; cpu_req high in the following IDLE cycle is a new access.
REQ-026 Byte lanes little-endian: addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24; halfword addr[1]=0 selects 15:0.
REQ-027 lb/lh sign-extend, lbu/lhu zero-extend; lw passes mem_rdata unchanged.
REQ-028 sb/sh merge replaces only the addressed byte/halfword of mem_rdata with cpu_wdata[7:0]/[15:0].
REQ-029 Watchdog: 8-bit counter clears on entry to RD/WR, increments each RD/WR cycle without ack; reaching TIMEOUT -> DONE with err=1, no write for an aborted RMW read.
REQ-030 cpu_rdata holds its value until the next completed load; stores and errors leave it unchanged.
REQ-031 Latency with zero-wait memory: load/sw 2 cycles from acceptance to cpu_done; sb/sh 3 cycles; error 1 cycle.
REQ-032 cpu_err is 0 whenever cpu_done is 0.

Reset
REQ-033 rstn=0 at a rising edge: state IDLE, cpu_rdata 0, write buffer 0, watchdog 0, err flag 0; hence mem_req, mem_we, cpu_done, cpu_err all 0.
REQ-034 Reset mid-access drops mem_req at that edge, produces no cpu_done, and never emits a partial RMW write.

Verification
REQ-035 lb, addr 0x103, mem_rdata 0x80FF_1234, ack immediate -> mem_addr 0x100, cpu_done 2 cycles after acceptance, cpu_rdata 0xFFFF_FF80, cpu_err 0.
REQ-036 sh, addr 0x202, wdata 0x0000_ABCD, read returns 0x1122_3344 -> one read, then write 0xABCD_3344 to 0x200, done 3 cycles after acceptance.
REQ-037 lw, addr 0x301 -> cpu_done 1 cycle after acceptance, cpu_err 1, mem_req never asserted.
REQ-038 sw, TIMEOUT=4, mem_ack held 0 -> mem_req high 4 cycles, then cpu_done with cpu_err 1.
REQ-039 lhu, mem_ack delayed 3 cycles, rstn pulsed low during the wait -> mem_req 0 after reset edge, no cpu_done, cpu_rdata 0.
REQ-040 Back-to-back lw then sb, cpu_req held high across cpu_done -> two independent accesses, second starts in the IDLE cycle after DONE.
